uart_tx: RTL and testbench

UART transmitter that serialises bytes onto the `tx` line in 8N1 format by default. Parity and stop-bit count are configurable. It is the transmit counterpart of the existing `uart_rx` and is paced by a one-cycle bit tick from the shared baud generator. The upstream side is a valid/ready handshake backed by a one-entry holding buffer, so back-to-back frames go out with no idle gap.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and default frame width.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_BITS = 8;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } uart_state_e;

    // Data is zero-extended to 8 bits, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding buffer in front of a tick-paced shift FSM.
// The state names the bit currently being driven on tx.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned PARITY    = PARITY_NONE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned      IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 busy_q, busy_d;
    logic                 load_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        load_c     = 1'b0;

        // Accept only into an empty buffer; a load can never coincide with a drain.
        if (tx_valid && tx_ready_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (buf_full_q) load_c = 1'b1;
                end
                S_START: begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    if (bit_idx_q < LAST_IDX) begin
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end else if (PARITY != PARITY_NONE) begin
                        tx_d    = par_q;
                        state_d = S_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
                    end
                end
                S_PARITY: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
                S_STOP: begin
                    if (STOP_BITS == 2 && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (buf_full_q) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end

        // Drain the buffer into the shift register and drive the start bit.
        if (load_c) begin
            shift_d    = buf_q;
            par_d      = parity_bit(8'(buf_q), PARITY);
            buf_full_d = 1'b0;
            tx_d       = 1'b0;
            state_d    = S_START;
        end
    end

    assign tx_ready_d = ~buf_full_d;
    assign busy_d     = (state_d != S_IDLE) || buf_full_d;

    assign tx_ready = tx_ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations share clock, reset and tick; the line is
// sampled on every tick and compared against frames built from the byte values.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int NI = 4;
    localparam int DB  [NI] = '{8, 8, 8, 5};
    localparam int PAR [NI] = '{0, 1, 2, 1};
    localparam int SB  [NI] = '{1, 1, 1, 2};

    logic          clk;
    logic          reset;
    logic          baud_tick;
    logic [7:0]    td [NI];
    logic [NI-1:0] tv;
    logic [NI-1:0] rdy;
    logic [NI-1:0] txl;
    logic [NI-1:0] bsy;

    logic       rec [NI][$];
    int         glitch [NI];
    logic       prev [NI];
    logic [7:0] bq [$];
    int         tests;
    int         fails;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) u0 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(td[0]),
        .tx_valid(tv[0]), .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]));
    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) u1 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(td[1]),
        .tx_valid(tv[1]), .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]));
    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) u2 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(td[2]),
        .tx_valid(tv[2]), .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]));
    uart_tx #(.DATA_BITS(5), .STOP_BITS(2), .PARITY(1)) u3 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(td[3][4:0]),
        .tx_valid(tv[3]), .tx_ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle bit tick every 8 clocks.
    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (7) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    // Line recorder: one sample per tick; any level change off a tick edge is a glitch.
    initial begin
        logic tk;
        logic rs;
        for (int k = 0; k < NI; k++) begin
            prev[k]   = 1'b1;
            glitch[k] = 0;
        end
        forever begin
            @(posedge clk);
            tk = baud_tick;
            rs = reset;
            #1;
            for (int k = 0; k < NI; k++) begin
                if (!(rs || reset)) begin
                    if (tk) rec[k].push_back(txl[k]);
                    else if (txl[k] !== prev[k]) glitch[k]++;
                end
                prev[k] = txl[k];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits.
    function automatic int model_frame(input int k, input logic [7:0] b, output logic [15:0] bits);
        int   n;
        logic p;
        bits = '0;
        n    = 0;
        bits[4'(n)] = 1'b0;
        n++;
        for (int i = 0; i < DB[k]; i++) begin
            bits[4'(n)] = b[3'(i)];
            n++;
        end
        if (PAR[k] != PARITY_NONE) begin
            p = 1'($countones(b & 8'((1 << DB[k]) - 1)) % 2);
            if (PAR[k] == PARITY_ODD) p = ~p;
            bits[4'(n)] = p;
            n++;
        end
        for (int i = 0; i < SB[k]; i++) begin
            bits[4'(n)] = 1'b1;
            n++;
        end
        return n;
    endfunction

    function automatic int first_zero(input int k);
        int i = 0;
        while (i < rec[k].size() && rec[k][i] !== 1'b0) i++;
        return i;
    endfunction

    task automatic clr_rec();
        for (int k = 0; k < NI; k++) rec[k].delete();
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (baud_tick !== 1'b1);
        end
        #2;
    endtask

    task automatic send(input int k, input logic [7:0] b, input int hold, input string tag);
        bit   done = 1'b0;
        logic r;
        @(negedge clk);
        td[k] = b;
        tv[k] = 1'b1;
        for (int c = 0; c < 3000 && !done; c++) begin
            r = rdy[k];
            @(posedge clk);
            if (r) done = 1'b1;
            else @(negedge clk);
        end
        check({tag, " accepted"}, 32'(done), 32'd1);
        if (hold == 0) #1;
        else repeat (hold) @(negedge clk);
        tv[k] = 1'b0;
        td[k] = 8'($urandom);
    endtask

    task automatic wait_idle(input int k, input string tag);
        int c = 0;
        @(negedge clk);
        while (bsy[k] !== 1'b0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({tag, " idle in time"}, 32'(bsy[k]), 32'd0);
    endtask

    task automatic check_stream(input int k, input logic [7:0] bytes[$], input bit contig,
                                input string tag);
        int          idx;
        int          len;
        int          bad;
        logic [15:0] expv;
        logic [15:0] obs;
        idx = (bytes.size() > 0) ? first_zero(k) : 0;
        foreach (bytes[i]) begin
            len = model_frame(k, bytes[i], expv);
            obs = '0;
            for (int j = 0; j < len; j++)
                obs[4'(j)] = (idx + j < rec[k].size()) ? rec[k][idx + j] : 1'bx;
            check($sformatf("%s u%0d frame%0d", tag, k, i), 32'(obs), 32'(expv));
            idx += len;
            if (!contig) while (idx < rec[k].size() && rec[k][idx] === 1'b1) idx++;
        end
        bad = 0;
        for (int j = idx; j < rec[k].size(); j++) if (rec[k][j] !== 1'b1) bad++;
        check($sformatf("%s u%0d idle tail", tag, k), 32'(bad), 32'd0);
    endtask

    initial begin
        int         s;
        logic [7:0] b;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        tv    = '0;
        for (int k = 0; k < NI; k++) td[k] = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset while idle, then ticks with nothing to send.
        repeat ($urandom_range(5, 20)) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst u%0d tx", k), 32'(txl[k]), 32'd1);
            check($sformatf("rst u%0d tx_ready", k), 32'(rdy[k]), 32'd1);
            check($sformatf("rst u%0d busy", k), 32'(bsy[k]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        clr_rec();
        wait_ticks(3);
        bq.delete();
        for (int k = 0; k < NI; k++) begin
            check_stream(k, bq, 1'b0, "idle");
            check($sformatf("idle u%0d tx", k), 32'(txl[k]), 32'd1);
        end

        // Single 8N1 frame; busy drops on the tick that ends the stop bit.
        clr_rec();
        send(0, 8'h55, 0, "t55");
        wait_idle(0, "t55");
        s = first_zero(0);
        check("t55 busy falls after stop", 32'(rec[0].size()), 32'(s + 11));
        wait_ticks(2);
        bq.delete();
        bq.push_back(8'h55);
        check_stream(0, bq, 1'b1, "t55");

        // Back-to-back frames with the second byte taken during the first start bit.
        clr_rec();
        send(0, 8'hA5, 0, "tA5");
        send(0, 8'h3C, 0, "t3C");
        check("t3C accepted during start bit", 32'(txl[0]), 32'd0);
        check("t3C buffer full", 32'(rdy[0]), 32'd0);
        wait_idle(0, "b2b");
        wait_ticks(2);
        bq.delete();
        bq.push_back(8'hA5);
        bq.push_back(8'h3C);
        check_stream(0, bq, 1'b1, "b2b");

        // Even and odd parity on 0x07.
        clr_rec();
        send(1, 8'h07, 0, "even");
        send(2, 8'h07, 0, "odd");
        wait_idle(1, "even");
        wait_idle(2, "odd");
        wait_ticks(2);
        check("even parity bit", 32'(rec[1][first_zero(1) + 9]), 32'd1);
        check("odd parity bit", 32'(rec[2][first_zero(2) + 9]), 32'd0);
        bq.delete();
        bq.push_back(8'h07);
        check_stream(1, bq, 1'b1, "even");
        check_stream(2, bq, 1'b1, "odd");

        // Two stop bits; second byte held valid across the full-buffer window.
        clr_rec();
        send(3, 8'h5A, 0, "s2a");
        send(3, 8'hFF, 3, "s2b");
        wait_idle(3, "stop2");
        wait_ticks(3);
        bq.delete();
        bq.push_back(8'h5A);
        bq.push_back(8'hFF);
        check_stream(3, bq, 1'b1, "stop2");

        // Reset during data bit 3 with a byte waiting in the buffer.
        clr_rec();
        send(0, 8'h81, 0, "r81");
        send(0, 8'h99, 0, "r99");
        wait_ticks(4);
        check("mid bit3 level", 32'(txl[0]), 32'd0);
        check("mid buffer full", 32'(rdy[0]), 32'd0);
        check("mid busy", 32'(bsy[0]), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("async rst tx", 32'(txl[0]), 32'd1);
        check("async rst tx_ready", 32'(rdy[0]), 32'd1);
        check("async rst busy", 32'(bsy[0]), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clr_rec();
        wait_ticks(4);
        bq.delete();
        check_stream(0, bq, 1'b0, "post rst discard");
        send(0, 8'h81, 0, "r81b");
        wait_idle(0, "r81b");
        wait_ticks(2);
        bq.push_back(8'h81);
        check_stream(0, bq, 1'b1, "post rst");

        // Random bytes with random gaps on every configuration.
        for (int k = 0; k < NI; k++) begin
            clr_rec();
            bq.delete();
            for (int n = 0; n < 6; n++) begin
                b = 8'($urandom);
                bq.push_back(b);
                repeat ($urandom_range(0, 30)) @(negedge clk);
                send(k, b, 0, $sformatf("rand u%0d", k));
            end
            wait_idle(k, "rand");
            wait_ticks(2);
            check_stream(k, bq, 1'b0, "rand");
        end

        for (int k = 0; k < NI; k++)
            check($sformatf("u%0d off-tick changes", k), 32'(glitch[k]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
